instruction_memory_loader: RTL and testbench

Parametrised instruction memory with a built-in sequential loader. Words arrive on a streaming write port during a LOAD phase at auto-incrementing word addresses, then the block switches to RUN and serves registered, byte-addressed instruction fetches to the fetch stage. Misaligned and out-of-range fetches are flagged and return a zero (NOP) word. It replaces the fixed 32-bit instruction memory and sits between the program loader/testbench stimulus and the PC/fetch logic.

---
 rtl/instruction_memory_loader.sv | 119 +++++++++++
 tb/tb_instruction_memory_loader.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_memory_loader.sv
// Instruction memory with a sequential streaming loader, then byte-addressed fetch in RUN.
// Latency: writes visible to fetches one edge later; fetch data/fault/valid registered, 1 cycle.
// Backpressure: none; write accepted every cycle in LOAD, one fetch per cycle in RUN, no stalls.
module instruction_memory_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                           CLk,
  input  logic                           reset,
  input  logic                           loadStart,
  input  logic                           write,
  input  logic [DATA_WIDTH-1:0]          memoryInput,
  input  logic                           loadEnd,
  input  logic [ADDR_WIDTH-1:0]          address,
  input  logic                           readEnable,
  output logic [DATA_WIDTH-1:0]          instruction,
  output logic                           instrValid,
  output logic                           fault,
  output logic                           loadDone,
  output logic [$clog2(DEPTH+1)-1:0]     loadCount
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  // Full-width bound so a non-power-of-two DEPTH is range-checked exactly
  localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t                state;
  logic [PTR_W-1:0]      wr_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [IDX_W-1:0] fetch_idx;
  logic             misaligned;
  logic             out_of_range;
  logic             mem_we;

  // Decode fetch address and the memory write strobe
  always_comb begin
    fetch_idx    = address[ADDR_WIDTH-1:2];
    misaligned   = (address[1:0] != 2'b00);
    out_of_range = (fetch_idx >= DEPTH_IDX);
    // Reset wins over a write in the same cycle, so an abandoned load stores nothing more
    mem_we       = (state == LOAD) && write && !reset;
  end

  // Storage array: no reset, contents survive reset and reload
  always_ff @(posedge CLk) begin
    if (mem_we) begin
      mem[wr_ptr] <= memoryInput;
    end
  end

  // Control FSM with registered fetch outputs and load status
  always_ff @(posedge CLk) begin
    if (reset) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      loadCount   <= '0;
      loadDone    <= 1'b0;
      instruction <= '0;
      instrValid  <= 1'b0;
      fault       <= 1'b0;
    end else begin
      // Valid and fault are single-cycle pulses tied to an accepted fetch
      instrValid <= 1'b0;
      fault      <= 1'b0;
      case (state)
        IDLE: begin
          if (loadStart) begin
            state     <= LOAD;
            wr_ptr    <= '0;
            loadCount <= '0;
            loadDone  <= 1'b0;
          end
        end
        LOAD: begin
          if (write) begin
            wr_ptr    <= wr_ptr + 1'b1;
            loadCount <= loadCount + 1'b1;
          end
          // Leaving on the last slot means the memory can never overflow
          if ((write && (wr_ptr == LAST_PTR)) || loadEnd) begin
            state    <= RUN;
            loadDone <= 1'b1;
          end
        end
        RUN: begin
          if (loadStart) begin
            // Reload takes priority; any fetch requested this cycle is dropped
            state     <= LOAD;
            wr_ptr    <= '0;
            loadCount <= '0;
            loadDone  <= 1'b0;
          end else if (readEnable) begin
            instrValid <= 1'b1;
            if (misaligned || out_of_range) begin
              instruction <= '0;
              fault       <= 1'b1;
            end else begin
              instruction <= mem[fetch_idx[PTR_W-1:0]];
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Directed bench for instruction_memory_loader (DEPTH=16, 32-bit words).
// Inputs change 1 time unit after a rising edge; outputs are checked at the same point.
// Expected values are hand-computed per vector.
module tb_instruction_memory_loader;

  logic        CLk;
  logic        reset;
  logic        loadStart;
  logic        write;
  logic [31:0] memoryInput;
  logic        loadEnd;
  logic [31:0] address;
  logic        readEnable;
  logic [31:0] instruction;
  logic        instrValid;
  logic        fault;
  logic        loadDone;
  logic [4:0]  loadCount;

  int n_tests = 0;
  int n_fail  = 0;

  instruction_memory_loader #(
    .DATA_WIDTH(32),
    .DEPTH(16),
    .ADDR_WIDTH(32)
  ) dut (
    .CLk(CLk),
    .reset(reset),
    .loadStart(loadStart),
    .write(write),
    .memoryInput(memoryInput),
    .loadEnd(loadEnd),
    .address(address),
    .readEnable(readEnable),
    .instruction(instruction),
    .instrValid(instrValid),
    .fault(fault),
    .loadDone(loadDone),
    .loadCount(loadCount)
  );

  initial CLk = 1'b0;
  always #5 CLk = ~CLk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLk);
    #1;
  endtask

  // One fetch cycle followed by checks of data, valid and fault
  task automatic fetch(input string tag, input logic [31:0] addr,
                       input logic [31:0] exp_data, input logic exp_fault);
    readEnable = 1'b1;
    address    = addr;
    tick();
    readEnable = 1'b0;
    check({tag, "_data"},  instruction, exp_data);
    check({tag, "_valid"}, {31'd0, instrValid}, 32'd1);
    check({tag, "_fault"}, {31'd0, fault}, {31'd0, exp_fault});
  endtask

  task automatic wr(input logic [31:0] d, input logic last);
    write       = 1'b1;
    memoryInput = d;
    loadEnd     = last;
    tick();
    write   = 1'b0;
    loadEnd = 1'b0;
  endtask

  initial begin
    reset = 1'b1; loadStart = 1'b0; write = 1'b0; memoryInput = '0;
    loadEnd = 1'b0; address = '0; readEnable = 1'b0;
    tick();
    tick();
    check("rst_instr", instruction, 32'd0);
    check("rst_valid", {31'd0, instrValid}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_done",  {31'd0, loadDone}, 32'd0);
    check("rst_count", {27'd0, loadCount}, 32'd0);
    reset = 1'b0;

    // Fetch in IDLE is ignored
    readEnable = 1'b1;
    tick();
    readEnable = 1'b0;
    check("idle_fetch_valid", {31'd0, instrValid}, 32'd0);

    // Full-stream load 0..15 with a fetch request held during LOAD
    loadStart = 1'b1;
    tick();
    loadStart = 1'b0;
    for (int i = 0; i < 16; i++) begin
      readEnable  = 1'b1;
      address     = 32'h0;
      write       = 1'b1;
      memoryInput = i;
      tick();
      if (i == 3) check("load_fetch_valid", {31'd0, instrValid}, 32'd0);
      if (i == 7) check("load_done_low", {31'd0, loadDone}, 32'd0);
    end
    write = 1'b0; readEnable = 1'b0;
    check("full_valid_last", {31'd0, instrValid}, 32'd0);
    check("full_done",  {31'd0, loadDone}, 32'd1);
    check("full_count", {27'd0, loadCount}, 32'd16);

    fetch("f3c", 32'h3C, 32'd15, 1'b0);
    tick();
    check("idle_valid_low", {31'd0, instrValid}, 32'd0);
    check("instr_hold", instruction, 32'd15);

    fetch("mis06", 32'h06, 32'd0, 1'b1);
    fetch("oob40", 32'h40, 32'd0, 1'b1);
    fetch("f08",   32'h08, 32'd2, 1'b0);
    fetch("oobbig", 32'h1000_0000, 32'd0, 1'b1);

    // Write in RUN must not modify memory
    write = 1'b1; memoryInput = 32'hDEAD;
    tick();
    write = 1'b0;
    fetch("run_wr_ignored", 32'h00, 32'd0, 1'b0);
    check("count_stable", {27'd0, loadCount}, 32'd16);

    // Back-to-back fetches
    readEnable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      address = i * 4;
      tick();
      check("b2b_valid", {31'd0, instrValid}, 32'd1);
      check("b2b_data",  instruction, i);
    end
    readEnable = 1'b0;

    // loadStart with a fetch in RUN: fetch dropped, loadDone falls
    loadStart = 1'b1; readEnable = 1'b1; address = 32'h4;
    tick();
    loadStart = 1'b0; readEnable = 1'b0;
    check("reload_valid", {31'd0, instrValid}, 32'd0);
    check("reload_done",  {31'd0, loadDone}, 32'd0);
    check("reload_count", {27'd0, loadCount}, 32'd0);

    // Gapped early-end load 0xA0..0xA4
    wr(32'hA0, 1'b0);
    tick();
    wr(32'hA1, 1'b0);
    tick();
    tick();
    check("gap_count", {27'd0, loadCount}, 32'd2);
    wr(32'hA2, 1'b0);
    wr(32'hA3, 1'b0);
    check("gap_done_low", {31'd0, loadDone}, 32'd0);
    wr(32'hA4, 1'b1);
    check("early_count", {27'd0, loadCount}, 32'd5);
    check("early_done",  {31'd0, loadDone}, 32'd1);
    fetch("e10", 32'h10, 32'hA4, 1'b0);
    fetch("e04", 32'h04, 32'hA1, 1'b0);
    fetch("e14_old", 32'h14, 32'd5, 1'b0);

    // Empty load: loadEnd alone still enters RUN
    loadStart = 1'b1;
    tick();
    loadStart = 1'b0;
    loadEnd = 1'b1;
    tick();
    loadEnd = 1'b0;
    check("empty_count", {27'd0, loadCount}, 32'd0);
    check("empty_done",  {31'd0, loadDone}, 32'd1);
    fetch("empty_keep", 32'h10, 32'hA4, 1'b0);

    // Reset mid-load, with a write on the reset cycle that must be dropped
    loadStart = 1'b1;
    tick();
    loadStart = 1'b0;
    wr(32'h77, 1'b0);
    wr(32'h78, 1'b0);
    wr(32'h79, 1'b0);
    reset = 1'b1; write = 1'b1; memoryInput = 32'h99;
    tick();
    reset = 1'b0; write = 1'b0;
    check("mrst_instr", instruction, 32'd0);
    check("mrst_valid", {31'd0, instrValid}, 32'd0);
    check("mrst_done",  {31'd0, loadDone}, 32'd0);
    check("mrst_count", {27'd0, loadCount}, 32'd0);

    loadStart = 1'b1;
    tick();
    loadStart = 1'b0;
    wr(32'h11, 1'b0);
    wr(32'h22, 1'b0);
    loadEnd = 1'b1;
    tick();
    loadEnd = 1'b0;
    check("rl_count", {27'd0, loadCount}, 32'd2);
    check("rl_done",  {31'd0, loadDone}, 32'd1);
    fetch("rl00", 32'h00, 32'h11, 1'b0);
    fetch("rl04", 32'h04, 32'h22, 1'b0);
    fetch("rl08", 32'h08, 32'h79, 1'b0);
    fetch("rl0c", 32'h0C, 32'hA3, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
